// File: rtl/grant_ack_pkg.sv
// Shared sizing defaults and types for the GrantAck sink-ID tracker.
package grant_ack_pkg;

    localparam int DEF_NUM_SINKS      = 8;
    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1023;
    localparam int WDOG_W             = 10;

    typedef logic [2:0]        sink_id_t;
    typedef logic [1:0]        owner_t;
    typedef logic [3:0]        count_t;
    typedef logic [WDOG_W-1:0] wdog_t;

    function automatic count_t popcount(input logic [DEF_NUM_SINKS-1:0] v);
        count_t n;
        n = '0;
        for (int i = 0; i < DEF_NUM_SINKS; i++) begin
            n = n + count_t'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/grant_ack_tracker_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr_i.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    int idx;

    // Walk from the farthest candidate back to ptr_i so the closest requester wins.
    always_comb begin
        gnt_o = '0;
        idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % N;
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/grant_ack_tracker.sv
// Sink-ID allocator with GrantAck release tracking.
// Optional GRANT_ACK_TIMEOUT_EN adds per-ID watchdogs and a sticky io_timeout output.
module grant_ack_tracker
    import grant_ack_pkg::*;
#(
    parameter int NUM_SINKS      = DEF_NUM_SINKS,
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] io_alloc_req,
    output logic [NUM_REQ-1:0] io_alloc_gnt,
    output sink_id_t           io_alloc_sink,
    input  logic               io_e_valid,
    input  sink_id_t           io_e_bits_sink,
    output logic               io_resp_valid,
    output sink_id_t           io_resp_bits_sink,
    output owner_t             io_resp_owner,
    output count_t             io_busy_count,
    output logic               io_err_spurious
`ifdef GRANT_ACK_TIMEOUT_EN
    ,
    output logic               io_timeout
`endif
);

    logic [NUM_SINKS-1:0] busy_q, busy_d;
    owner_t               owner_q [NUM_SINKS];
    owner_t               owner_d [NUM_SINKS];
    owner_t               rr_ptr_q, rr_ptr_d;
    logic                 resp_valid_q, resp_valid_d;
    sink_id_t             resp_sink_q, resp_sink_d;
    owner_t               resp_owner_q, resp_owner_d;
    count_t               busy_count_q;
    logic                 err_q, err_d;

    logic                 full;
    sink_id_t             free_id;
    owner_t               gnt_idx;
    logic [NUM_REQ-1:0]   arb_gnt;
    logic                 ack_hit;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW ($bits(owner_t))
    ) u_arb (
        .req_i (io_alloc_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt)
    );

    // Free-ID search uses only the registered mask, so an ID released this cycle waits a cycle.
    always_comb begin
        full    = &busy_q;
        free_id = '0;
        for (int i = NUM_SINKS - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_id = sink_id_t'(i);
        end
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_gnt[k]) gnt_idx = owner_t'(k);
        end
    end

    assign io_alloc_gnt  = full ? '0 : arb_gnt;
    assign io_alloc_sink = free_id;
    assign ack_hit       = io_e_valid && busy_q[io_e_bits_sink];

    always_comb begin
        busy_d       = busy_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        resp_valid_d = ack_hit;
        resp_sink_d  = resp_sink_q;
        resp_owner_d = resp_owner_q;
        err_d        = io_e_valid && !busy_q[io_e_bits_sink];
        if (ack_hit) begin
            busy_d[io_e_bits_sink] = 1'b0;
            resp_sink_d            = io_e_bits_sink;
            resp_owner_d           = owner_q[io_e_bits_sink];
        end
        if (|io_alloc_gnt) begin
            busy_d[free_id]  = 1'b1;
            owner_d[free_id] = gnt_idx;
            rr_ptr_d         = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q       <= '0;
            owner_q      <= '{default: '0};
            rr_ptr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_sink_q  <= '0;
            resp_owner_q <= '0;
            busy_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_sink_q  <= resp_sink_d;
            resp_owner_q <= resp_owner_d;
            busy_count_q <= popcount(busy_d);
            err_q        <= err_d;
        end
    end

    assign io_resp_valid     = resp_valid_q;
    assign io_resp_bits_sink = resp_sink_q;
    assign io_resp_owner     = resp_owner_q;
    assign io_busy_count     = busy_count_q;
    assign io_err_spurious   = err_q;

`ifdef GRANT_ACK_TIMEOUT_EN
    wdog_t wdog_q [NUM_SINKS];
    logic  timeout_q;

    // Counters saturate at the limit; the flag stays set until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdog_q    <= '{default: '0};
            timeout_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SINKS; i++) begin
                if (|io_alloc_gnt && free_id == sink_id_t'(i)) begin
                    wdog_q[i] <= '0;
                end else if (busy_q[i] && wdog_q[i] != wdog_t'(TIMEOUT_CYCLES)) begin
                    wdog_q[i] <= wdog_q[i] + 1'b1;
                end
                if (busy_q[i] && wdog_q[i] == wdog_t'(TIMEOUT_CYCLES)) timeout_q <= 1'b1;
            end
        end
    end

    assign io_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_grant_ack_tracker.sv
// Self-checking bench for grant_ack_tracker: directed vector table, corner sequences, random vs. model.
module tb_grant_ack_tracker;
    import grant_ack_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = '0;
    logic       ev    = 1'b0;
    logic [2:0] es    = '0;

    logic [3:0] gnt;
    sink_id_t   gsink;
    logic       rv;
    sink_id_t   rsink;
    owner_t     rown;
    count_t     cnt;
    logic       err;
`ifdef GRANT_ACK_TIMEOUT_EN
    logic       tmo;
`endif

    grant_ack_tracker dut (
        .clock             (clock),
        .reset             (reset),
        .io_alloc_req      (req),
        .io_alloc_gnt      (gnt),
        .io_alloc_sink     (gsink),
        .io_e_valid        (ev),
        .io_e_bits_sink    (es),
        .io_resp_valid     (rv),
        .io_resp_bits_sink (rsink),
        .io_resp_owner     (rown),
        .io_busy_count     (cnt),
        .io_err_spurious   (err)
`ifdef GRANT_ACK_TIMEOUT_EN
        ,
        .io_timeout        (tmo)
`endif
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Behavioural model: set of busy IDs, who owns each, and the next MSHR in line.
    bit mbusy [8];
    int mowner[8];
    int mrr;
    bit mresp_v;
    int mresp_s, mresp_o;
    bit merr;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mbusy[i]  = 1'b0;
            mowner[i] = 0;
        end
        mrr = 0; mresp_v = 1'b0; mresp_s = 0; mresp_o = 0; merr = 1'b0;
    endtask

    function automatic int model_nbusy();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    function automatic int model_grant(input logic [3:0] r);
        if (model_nbusy() == 8) return -1;
        for (int k = 0; k < 4; k++) if (r[(mrr + k) % 4]) return (mrr + k) % 4;
        return -1;
    endfunction

    function automatic int model_free();
        for (int i = 0; i < 8; i++) if (!mbusy[i]) return i;
        return 0;
    endfunction

    task automatic model_compare(input string tag);
        int g;
        g = model_grant(req);
        chk({tag, "_gnt"}, int'(gnt), (g < 0) ? 0 : (1 << g));
        if (g >= 0) chk({tag, "_gsink"}, int'(gsink), model_free());
        chk({tag, "_rv"}, int'(rv), int'(mresp_v));
        if (mresp_v) begin
            chk({tag, "_rsink"}, int'(rsink), mresp_s);
            chk({tag, "_rown"}, int'(rown), mresp_o);
        end
        chk({tag, "_err"}, int'(err), int'(merr));
        chk({tag, "_cnt"}, int'(cnt), model_nbusy());
    endtask

    task automatic model_step();
        int g, f;
        g = model_grant(req);
        f = model_free();
        mresp_v = ev && mbusy[es];
        merr    = ev && !mbusy[es];
        if (mresp_v) begin
            mresp_s   = int'(es);
            mresp_o   = mowner[es];
            mbusy[es] = 1'b0;
        end
        if (g >= 0) begin
            mbusy[f]  = 1'b1;
            mowner[f] = g;
            mrr       = (g + 1) % 4;
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; req = '0; ev = 1'b0; es = '0;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [3:0] req;
        bit         ev;
        int         es;
        logic [3:0] gnt;
        int         sink;
        bit         rv;
        int         rs;
        int         ro;
        int         cnt;
        bit         err;
    } vec_t;

    vec_t tbl[18];

    initial begin
        //            req    ev es  gnt    sk rv rs ro cnt err
        tbl[0]  = '{4'b1111, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{4'b1111, 0, 0, 4'b0010, 1, 0, 0, 0, 1, 0};
        tbl[2]  = '{4'b1111, 0, 0, 4'b0100, 2, 0, 0, 0, 2, 0};
        tbl[3]  = '{4'b1111, 0, 0, 4'b1000, 3, 0, 0, 0, 3, 0};
        tbl[4]  = '{4'b1111, 0, 0, 4'b0001, 4, 0, 0, 0, 4, 0};
        tbl[5]  = '{4'b1111, 0, 0, 4'b0010, 5, 0, 0, 0, 5, 0};
        tbl[6]  = '{4'b1111, 0, 0, 4'b0100, 6, 0, 0, 0, 6, 0};
        tbl[7]  = '{4'b1111, 0, 0, 4'b1000, 7, 0, 0, 0, 7, 0};
        tbl[8]  = '{4'b1111, 0, 0, 4'b0000, 0, 0, 0, 0, 8, 0};
        tbl[9]  = '{4'b0001, 1, 5, 4'b0000, 0, 0, 0, 0, 8, 0};
        tbl[10] = '{4'b0001, 0, 0, 4'b0001, 5, 1, 5, 1, 7, 0};
        tbl[11] = '{4'b0010, 1, 2, 4'b0000, 0, 0, 0, 0, 8, 0};
        tbl[12] = '{4'b0000, 0, 0, 4'b0000, 0, 1, 2, 2, 7, 0};
        tbl[13] = '{4'b0000, 1, 2, 4'b0000, 0, 0, 0, 0, 7, 0};
        tbl[14] = '{4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 7, 1};
        tbl[15] = '{4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 7, 0};
        tbl[16] = '{4'b1100, 0, 0, 4'b0100, 2, 0, 0, 0, 7, 0};
        tbl[17] = '{4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 8, 0};

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_rv", int'(rv), 0);
        chk("rst_err", int'(err), 0);
        do_reset();

        // Fill/drain/spurious sequence from the vector table
        for (int i = 0; i < 18; i++) begin
            req = tbl[i].req; ev = tbl[i].ev; es = 3'(tbl[i].es);
            #1;
            chk($sformatf("vec%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
            if (tbl[i].gnt != 0) chk($sformatf("vec%0d_gsink", i), int'(gsink), tbl[i].sink);
            chk($sformatf("vec%0d_rv", i), int'(rv), int'(tbl[i].rv));
            if (tbl[i].rv) begin
                chk($sformatf("vec%0d_rsink", i), int'(rsink), tbl[i].rs);
                chk($sformatf("vec%0d_rown", i), int'(rown), tbl[i].ro);
            end
            chk($sformatf("vec%0d_cnt", i), int'(cnt), tbl[i].cnt);
            chk($sformatf("vec%0d_err", i), int'(err), int'(tbl[i].err));
            step();
        end
        req = '0; ev = 1'b0;

        // First grant after reset, then pointer advanced to MSHR 1
        do_reset();
        req = 4'b0001;
        #1;
        chk("first_gnt", int'(gnt), 1);
        chk("first_sink", int'(gsink), 0);
        step();
        req = 4'b1111;
        #1;
        chk("first_cnt", int'(cnt), 1);
        chk("rr_ptr1_gnt", int'(gnt), 2);
        chk("rr_ptr1_sink", int'(gsink), 1);
        req = '0;

        // Spurious ack on an idle tracker
        do_reset();
        ev = 1'b1; es = 3'd6;
        step();
        ev = 1'b0;
        #1;
        chk("spur_err", int'(err), 1);
        chk("spur_rv", int'(rv), 0);
        chk("spur_cnt", int'(cnt), 0);
        step();
        #1;
        chk("spur_err_drop", int'(err), 0);

        // Asynchronous reset with three IDs busy and an ack in flight
        do_reset();
        req = 4'b0001;
        repeat (3) step();
        req = '0; ev = 1'b1; es = 3'd1;
        #1;
        chk("pre_rst_cnt", int'(cnt), 3);
        reset = 1'b1;
        #1;
        chk("mid_rst_cnt", int'(cnt), 0);
        chk("mid_rst_rv", int'(rv), 0);
        chk("mid_rst_err", int'(err), 0);
        chk("mid_rst_rsink", int'(rsink), 0);
        chk("mid_rst_rown", int'(rown), 0);
        step();
        reset = 1'b0; ev = 1'b0; req = 4'b0100;
        #1;
        chk("post_rst_gnt", int'(gnt), 4);
        chk("post_rst_sink", int'(gsink), 0);
        chk("post_rst_rv", int'(rv), 0);
        step();
        req = '0;
        #1;
        chk("post_rst_cnt", int'(cnt), 1);

        // Random traffic against the model, with occasional mid-run resets
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1; req = '0; ev = 1'b0;
                model_reset();
                #1;
                model_compare($sformatf("rnd%0d_rst", c));
                step();
                reset = 1'b0;
            end else begin
                req = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
                ev  = ($urandom_range(0, 9) < 4);
                es  = 3'($urandom_range(0, 7));
                #1;
                model_compare($sformatf("rnd%0d", c));
                model_step();
                step();
            end
        end
        req = '0; ev = 1'b0;

`ifdef GRANT_ACK_TIMEOUT_EN
        // Watchdog: sink 0 held busy past the limit, flag survives a later ack
        do_reset();
        req = 4'b0001;
        step();
        req = '0;
        repeat (1000) step();
        #1;
        chk("tmo_early", int'(tmo), 0);
        repeat (40) step();
        #1;
        chk("tmo_set", int'(tmo), 1);
        ev = 1'b1; es = 3'd0;
        step();
        ev = 1'b0;
        repeat (3) step();
        #1;
        chk("tmo_sticky", int'(tmo), 1);
        chk("tmo_cnt", int'(cnt), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
